// File: rtl/motion_update_broadcast_arbiter.sv
// Round-robin arbiter broadcasting motion-update beats from four requesters to every cell cache.
// Optional stall watchdog is built only when MU_ARB_TIMEOUT_EN is defined.
module motion_update_broadcast_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int CELL_ID_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [3:0]                   req_valid,
    input  logic [4*3*DATA_WIDTH-1:0]    req_data,
    input  logic [4*3*CELL_ID_WIDTH-1:0] req_dst_cell,
    input  logic [3:0]                   req_done,
    output logic [3:0]                   req_grant,
    output logic                         motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]      out_data,
    output logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell,
    output logic                         out_data_valid,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  beat_count,
    output logic                         timeout_err
);
    localparam int BW = 3 * DATA_WIDTH;
    localparam int CW = 3 * CELL_ID_WIDTH;

    typedef enum logic [2:0] {IDLE, BROADCAST, DRAIN, SETTLE, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      settle_cnt_q, settle_cnt_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0]      done_flags_q, done_flags_d;
    logic            enable_q, enable_d;
    logic [BW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_dst_q, out_dst_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     beat_count_q, beat_count_d;
    logic [3:0]      cand;
    logic [1:0]      win_idx;
    logic            win_found;
    logic            launch;
    logic            timeout_hit;

    assign launch = (state_q == IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Next-state logic; BROADCAST exits on the same cycle the last done flag is captured
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            IDLE:      if (start) state_d = BROADCAST;
            BROADCAST: if (&done_flags_d) state_d = DRAIN;
            DRAIN: begin
                state_d      = SETTLE;
                settle_cnt_d = 2'd0;
            end
            SETTLE: begin
                if (settle_cnt_q == 2'd2) state_d = DONE;
                else                      settle_cnt_d = settle_cnt_q + 2'd1;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Round-robin search begins one past the last winner
    always_comb begin
        cand      = (state_q == BROADCAST) ? (req_valid & ~done_flags_q) : 4'b0000;
        win_idx   = 2'd0;
        win_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && cand[2'(rr_ptr_q + 2'(k))]) begin
                win_found = 1'b1;
                win_idx   = 2'(rr_ptr_q + 2'(k));
            end
        end
    end

    // Output logic
    always_comb begin
        req_grant = win_found ? (4'b0001 << win_idx) : 4'b0000;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

    always_comb begin
        done_flags_d = done_flags_q;
        rr_ptr_d     = rr_ptr_q;
        beat_count_d = beat_count_q;
        out_valid_d  = win_found;
        out_data_d   = '0;
        out_dst_d    = '0;
        enable_d     = (state_d == BROADCAST) || (state_d == DRAIN);
        if (launch) begin
            done_flags_d = 4'b0000;
            beat_count_d = 16'd0;
        end
        if (state_q == BROADCAST) begin
            done_flags_d = done_flags_q | req_done;
            if (timeout_hit) done_flags_d = 4'b1111;
        end
        if (win_found) begin
            rr_ptr_d   = win_idx;
            out_data_d = req_data[win_idx*BW +: BW];
            out_dst_d  = req_dst_cell[win_idx*CW +: CW];
            if (beat_count_q != 16'hFFFF) beat_count_d = beat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= 2'd3;
            done_flags_q <= 4'b0000;
            enable_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_dst_q    <= '0;
            beat_count_q <= 16'd0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            done_flags_q <= done_flags_d;
            enable_q     <= enable_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_dst_q    <= out_dst_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign motion_update_enable = enable_q;
    assign out_data_valid       = out_valid_q;
    assign out_data             = out_data_q;
    assign out_data_dst_cell    = out_dst_q;
    assign beat_count           = beat_count_q;

`ifdef MU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_err_q, timeout_err_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive grantless BROADCAST cycle
    always_comb begin
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = timeout_err_q;
        timeout_hit   = 1'b0;
        if (launch) begin
            idle_cnt_d    = '0;
            timeout_err_d = 1'b0;
        end else if (state_q == BROADCAST) begin
            if (win_found) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit   = 1'b1;
                timeout_err_d = 1'b1;
                idle_cnt_d    = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_motion_update_broadcast_arbiter.sv
// Directed self-checking bench for motion_update_broadcast_arbiter (watchdog scenario needs MU_ARB_TIMEOUT_EN).
module tb_motion_update_broadcast_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   req_valid;
    logic [383:0] req_data;
    logic [47:0]  req_dst_cell;
    logic [3:0]   req_done;
    logic [3:0]   req_grant;
    logic         motion_update_enable;
    logic [95:0]  out_data;
    logic [11:0]  out_data_dst_cell;
    logic         out_data_valid;
    logic         busy;
    logic         done;
    logic [15:0]  beat_count;
    logic         timeout_err;

    int checks   = 0;
    int failures = 0;

    motion_update_broadcast_arbiter #(
        .DATA_WIDTH(32), .CELL_ID_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid),
        .req_data(req_data), .req_dst_cell(req_dst_cell), .req_done(req_done),
        .req_grant(req_grant), .motion_update_enable(motion_update_enable),
        .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
        .out_data_valid(out_data_valid), .busy(busy), .done(done),
        .beat_count(beat_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] pk_data(int i, int b);
        return {32'(100 + i), 32'(b), 32'(i * 16 + b)};
    endfunction

    function automatic logic [11:0] pk_dst(int i, int b);
        return {4'(i), 4'(b), 4'(i + 1)};
    endfunction

    task automatic set_beats(int b);
        for (int i = 0; i < 4; i++) begin
            req_data[i*96 +: 96]   = pk_data(i, b);
            req_dst_cell[i*12 +: 12] = pk_dst(i, b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; req_valid = 4'h0; req_done = 4'h0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_done(string name, int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s: done pulse not seen within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; req_valid = 4'hF; req_done = 4'hF; set_beats(1);
        step(); step(); #1;
        checks++; if (req_grant !== 4'h0) begin failures++; $display("FAIL reset_grant: got %b expected 0000", req_grant); end
        checks++; if (motion_update_enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %b expected 0", motion_update_enable); end
        checks++; if (out_data_valid !== 1'b0 || out_data !== 96'd0 || out_data_dst_cell !== 12'd0) begin failures++; $display("FAIL reset_out: got valid=%b data=%h dst=%h expected all 0", out_data_valid, out_data, out_data_dst_cell); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_status: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (beat_count !== 16'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_counters: got beats=%0d terr=%b expected 0 0", beat_count, timeout_err); end
        rst = 1'b0; start = 1'b0; req_valid = 4'h0; req_done = 4'h0;
    endtask

    task automatic test_single();
        do_reset();
        start = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
        step(); start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            req_valid = 4'b0001; set_beats(b); req_done = (b == 4) ? 4'hF : 4'h0;
            #1;
            checks++; if (req_grant !== 4'b0001) begin failures++; $display("FAIL single_grant beat %0d: got %b expected 0001", b, req_grant); end
            checks++; if (out_data_valid !== 1'(b != 0)) begin failures++; $display("FAIL single_valid beat %0d: got %b expected %b", b, out_data_valid, 1'(b != 0)); end
            if (b == 0) begin
                checks++; if (motion_update_enable !== 1'b1) begin failures++; $display("FAIL single_enable_rise: got %b expected 1", motion_update_enable); end
            end else begin
                checks++; if (out_data !== pk_data(0, b - 1)) begin failures++; $display("FAIL single_data beat %0d: got %h expected %h", b - 1, out_data, pk_data(0, b - 1)); end
            end
            step();
        end
        req_valid = 4'h0; req_done = 4'h0; #1;
        checks++; if (out_data_valid !== 1'b1 || out_data !== pk_data(0, 4) || out_data_dst_cell !== pk_dst(0, 4)) begin failures++; $display("FAIL single_last_beat: got valid=%b data=%h dst=%h expected 1 %h %h", out_data_valid, out_data, out_data_dst_cell, pk_data(0, 4), pk_dst(0, 4)); end
        checks++; if (beat_count !== 16'd5) begin failures++; $display("FAIL single_beat_count: got %0d expected 5", beat_count); end
        checks++; if (motion_update_enable !== 1'b1) begin failures++; $display("FAIL single_enable_drain: got %b expected 1", motion_update_enable); end
        step();
        checks++; if (motion_update_enable !== 1'b0 || out_data_valid !== 1'b0 || out_data !== 96'd0) begin failures++; $display("FAIL single_enable_fall: got en=%b valid=%b data=%h expected 0 0 0", motion_update_enable, out_data_valid, out_data); end
        step(); step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_early: got %b expected 0", done); end
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done_pulse: got %b expected 1", done); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || beat_count !== 16'd5) begin failures++; $display("FAIL single_after_done: got done=%b busy=%b beats=%0d expected 0 0 5", done, busy, beat_count); end
    endtask

    task automatic test_contention();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        req_valid = 4'hF; set_beats(0);
        for (int k = 0; k < 12; k++) begin
            req_done = (k == 11) ? 4'hF : 4'h0;
            #1;
            checks++; if (req_grant !== (4'b0001 << (k % 4))) begin failures++; $display("FAIL contention_grant cycle %0d: got %b expected %b", k, req_grant, 4'b0001 << (k % 4)); end
            if (k > 0) begin
                checks++; if (out_data_valid !== 1'b1 || out_data !== pk_data((k - 1) % 4, 0)) begin failures++; $display("FAIL contention_out cycle %0d: got valid=%b data=%h expected 1 %h", k, out_data_valid, out_data, pk_data((k - 1) % 4, 0)); end
            end
            step();
        end
        req_valid = 4'h0; req_done = 4'h0; #1;
        checks++; if (beat_count !== 16'd12) begin failures++; $display("FAIL contention_beat_count: got %0d expected 12", beat_count); end
        wait_done("contention_done", 10);
        step();
    endtask

    task automatic test_ordering();
        logic [3:0] exp_g [10] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001,
                                   4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b1000};
        logic [3:0] dn [10]    = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                   4'h0, 4'b0001, 4'b0010, 4'h0, 4'b1000};
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        req_valid = 4'b0100; req_done = 4'b0100; set_beats(0); #1;
        checks++; if (req_grant !== 4'b0100) begin failures++; $display("FAIL order_same_cycle_grant: got %b expected 0100", req_grant); end
        step();
        req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            req_done = dn[k]; set_beats(k + 1); #1;
            checks++; if (req_grant !== exp_g[k]) begin failures++; $display("FAIL order_grant cycle %0d: got %b expected %b", k, req_grant, exp_g[k]); end
            checks++; if (motion_update_enable !== 1'b1) begin failures++; $display("FAIL order_enable cycle %0d: got %b expected 1", k, motion_update_enable); end
            step();
        end
        req_done = 4'h0; #1;
        checks++; if (motion_update_enable !== 1'b1 || req_grant !== 4'h0 || beat_count !== 16'd11) begin failures++; $display("FAIL order_drain: got en=%b grant=%b beats=%0d expected 1 0000 11", motion_update_enable, req_grant, beat_count); end
        step();
        checks++; if (motion_update_enable !== 1'b0) begin failures++; $display("FAIL order_settle_enable: got %b expected 0", motion_update_enable); end
        req_valid = 4'h0;
        wait_done("order_done", 6);
        step();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        req_valid = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            set_beats(b); step();
        end
        rst = 1'b1; step(); rst = 1'b0; #1;
        checks++; if (req_grant !== 4'h0 || motion_update_enable !== 1'b0 || out_data_valid !== 1'b0 || out_data !== 96'd0) begin failures++; $display("FAIL midreset_out: got grant=%b en=%b valid=%b data=%h expected all 0", req_grant, motion_update_enable, out_data_valid, out_data); end
        checks++; if (busy !== 1'b0 || beat_count !== 16'd0) begin failures++; $display("FAIL midreset_state: got busy=%b beats=%0d expected 0 0", busy, beat_count); end
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset_no_done: got %0d pulses expected 0", pulses); end
        req_valid = 4'h0; start = 1'b1; step(); start = 1'b0; #1;
        checks++; if (beat_count !== 16'd0 || motion_update_enable !== 1'b1) begin failures++; $display("FAIL midreset_restart: got beats=%0d en=%b expected 0 1", beat_count, motion_update_enable); end
        req_valid = 4'b0010; step(); req_valid = 4'h0; #1;
        checks++; if (beat_count !== 16'd1) begin failures++; $display("FAIL midreset_count: got %0d expected 1", beat_count); end
    endtask

    task automatic test_start_busy();
        int pulses = 0;
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        req_done = 4'hF; step(); req_done = 4'h0;
        step();
        start = 1'b1; #1;
        checks++; if (motion_update_enable !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL startbusy_settle: got en=%b busy=%b expected 0 1", motion_update_enable, busy); end
        step(); start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL startbusy_pulses: got %0d expected 1", pulses); end
        checks++; if (busy !== 1'b0 || beat_count !== 16'd0) begin failures++; $display("FAIL startbusy_idle: got busy=%b beats=%0d expected 0 0", busy, beat_count); end
    endtask

`ifdef MU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c == 8) begin
                checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b expected 0", timeout_err); end
            end
            step();
        end
        checks++; if (timeout_err !== 1'b1 || motion_update_enable !== 1'b1) begin failures++; $display("FAIL timeout_set: got terr=%b en=%b expected 1 1", timeout_err, motion_update_enable); end
        step();
        checks++; if (motion_update_enable !== 1'b0) begin failures++; $display("FAIL timeout_enable_fall: got %b expected 0", motion_update_enable); end
        step(); step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL timeout_done_early: got %b expected 0", done); end
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL timeout_done_pulse: got %b expected 1", done); end
        step();
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_sticky: got terr=%b busy=%b expected 1 0", timeout_err, busy); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
        do_reset();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 20; c++) step();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL no_watchdog: got terr=%b busy=%b done=%b expected 0 1 0", timeout_err, busy, done); end
        do_reset();
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; req_valid = 4'h0; req_done = 4'h0;
        req_data = '0; req_dst_cell = '0;
        test_reset();
        test_single();
        test_contention();
        test_ordering();
        test_reset_mid();
        test_start_busy();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
